hdmi_packet_assembler: RTL and testbench

Serializes one HDMI data-island packet (24-bit header plus four 56-bit subpackets) into the 9-bit per-pixel-clock stream consumed by the TERC4 channel encoders. It sits directly downstream of the packet sources (InfoFrames, audio clock regeneration, audio sample) and the packet picker that selects among them. It also computes and appends the BCH ECC parity bytes (one for the header, one per subpacket), so packet sources only supply payload and checksum fields.

---
 rtl/hdmi_packet_assembler.sv | 135 +++++++++++++
 tb/tb_hdmi_packet_assembler.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/hdmi_packet_assembler.sv
// hdmi_packet_assembler
//
// Serializes one HDMI data-island packet (24-bit header + four 56-bit
// subpackets) into the 9-bit-per-pixel stream that feeds the TERC4 encoders.
// The BCH parity bytes are generated on the fly and appended: header
// parity on bit 0 over counters 24..31, and subpacket parity on bits 1..8
// over counters 28..31.
//
// Ports
//   clk_pixel           in   pixel clock
//   reset               in   asynchronous, active-high reset
//   data_island_period  in   high on every data-period clock of an island
//   header      [23:0]  in   HB2:HB0, HB0 in [7:0]
//   sub        [223:0]  in   subpacket i in [56*i+55:56*i]
//   packet_data  [8:0]  out  bit 0 -> ch0 bit 2, [4:1] -> ch1, [8:5] -> ch2
//   counter      [4:0]  out  bit index within the packet, 0..31
//   packet_end          out  last cycle of a packet (counter==31 in island)
//
// Handshake: there is no back-pressure. The packet picker must present a
// packet whenever data_island_period is high; it is sampled on the
// counter==0 clock, and packet_end tells the picker to present the next one.
// Dropping data_island_period freezes all state, so a packet resumes where
// it stopped.

module hdmi_packet_assembler (
    input  logic         clk_pixel,
    input  logic         reset,
    input  logic         data_island_period,
    input  logic [23:0]  header,
    input  logic [223:0] sub,
    output logic [8:0]   packet_data,
    output logic [4:0]   counter,
    output logic         packet_end
);

    // One LSB-first step of the BCH generator x^8+x^7+x^6+1.
    function automatic logic [7:0] bch_next(input logic [7:0] e, input logic b);
        return (e >> 1) ^ (((e[0] ^ b) == 1'b1) ? 8'h83 : 8'h00);
    endfunction

    logic [4:0]        counter_q, counter_d;
    logic [23:0]       hdr_q, hdr_d;
    logic [223:0]      sub_q, sub_d;
    logic [7:0]        eh_q, eh_d;
    logic [3:0][7:0]   es_q, es_d;

    logic [23:0]       hdr_cur;
    logic [3:0][55:0]  sub_cur;
    logic [4:0]        c_hdr, c_sub;
    logic [5:0]        idx_even, idx_odd;
    logic              hdr_bit;
    logic [3:0]        bit_even, bit_odd;
    logic [8:0]        data_raw;

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            counter_q <= 5'd0;
            hdr_q     <= 24'd0;
            sub_q     <= 224'd0;
            eh_q      <= 8'd0;
            es_q      <= '0;
        end else begin
            counter_q <= counter_d;
            hdr_q     <= hdr_d;
            sub_q     <= sub_d;
            eh_q      <= eh_d;
            es_q      <= es_d;
        end
    end

    always_comb begin
        // Bit 0 of a packet is taken straight from the source; later bits
        // come from the copy captured on that same clock.
        hdr_cur = (counter_q == 5'd0) ? header : hdr_q;
        sub_cur = (counter_q == 5'd0) ? sub    : sub_q;

        // Indices are clamped to 0 in the parity phase so the payload
        // selects never go out of range; their result is unused there.
        c_hdr    = (counter_q < 5'd24) ? counter_q : 5'd0;
        c_sub    = (counter_q < 5'd28) ? counter_q : 5'd0;
        idx_even = {c_sub, 1'b0};
        idx_odd  = {c_sub, 1'b1};

        hdr_bit = hdr_cur[c_hdr];
        for (int i = 0; i < 4; i++) begin
            bit_even[i] = sub_cur[i][idx_even];
            bit_odd[i]  = sub_cur[i][idx_odd];
        end

        counter_d = counter_q;
        hdr_d     = hdr_q;
        sub_d     = sub_q;
        eh_d      = eh_q;
        es_d      = es_q;

        if (data_island_period) begin
            counter_d = counter_q + 5'd1;
            if (counter_q == 5'd0) begin
                hdr_d = header;
                sub_d = sub;
            end
            if (counter_q == 5'd31) begin
                // Clear on the last cycle so back-to-back packets start
                // from zero parity with no gap.
                eh_d = 8'd0;
                es_d = '0;
            end else begin
                if (counter_q < 5'd24) begin
                    eh_d = bch_next(eh_q, hdr_bit);
                end
                if (counter_q < 5'd28) begin
                    for (int i = 0; i < 4; i++) begin
                        es_d[i] = bch_next(bch_next(es_q[i], bit_even[i]), bit_odd[i]);
                    end
                end
            end
        end

        // Parity phase: counter-24 and counter-28 reduce to the low bits.
        data_raw[0] = (counter_q < 5'd24) ? hdr_bit : eh_q[counter_q[2:0]];
        for (int i = 0; i < 4; i++) begin
            data_raw[1 + i] = (counter_q < 5'd28) ? bit_even[i]
                                                  : es_q[i][{counter_q[1:0], 1'b0}];
            data_raw[5 + i] = (counter_q < 5'd28) ? bit_odd[i]
                                                  : es_q[i][{counter_q[1:0], 1'b1}];
        end
    end

    // Reset forces a quiet output even though counter 0 would otherwise
    // pass the live source bits through.
    assign packet_data = reset ? 9'h000 : data_raw;
    assign counter     = counter_q;
    assign packet_end  = data_island_period && (counter_q == 5'd31);

endmodule

// File: tb/tb_hdmi_packet_assembler.sv
module tb_hdmi_packet_assembler;

    logic         clk_pixel;
    logic         reset;
    logic         data_island_period;
    logic [23:0]  header;
    logic [223:0] sub;
    logic [8:0]   packet_data;
    logic [4:0]   counter;
    logic         packet_end;

    int n_cmp = 0;
    int n_bad = 0;

    logic [8:0] exp_stream [32];
    logic [7:0] got_hpar;

    hdmi_packet_assembler dut (
        .clk_pixel          (clk_pixel),
        .reset              (reset),
        .data_island_period (data_island_period),
        .header             (header),
        .sub                (sub),
        .packet_data        (packet_data),
        .counter            (counter),
        .packet_end         (packet_end)
    );

    // ---------------- clock / reset ----------------
    initial clk_pixel = 1'b0;
    always #5 clk_pixel = ~clk_pixel;

    // ---------------- reference model ----------------
    function automatic logic [7:0] ref_step(input logic [7:0] e, input logic b);
        logic [7:0] r;
        r = {1'b0, e[7:1]};
        if (e[0] ^ b) r = r ^ 8'h83;
        return r;
    endfunction

    // Builds the full 32-word stream for one packet from scratch.
    function automatic void build_stream(input logic [23:0] h, input logic [223:0] s);
        logic [7:0]  eh;
        logic [7:0]  es [4];
        logic [55:0] sp [4];
        eh = 8'd0;
        for (int k = 0; k < 24; k++) eh = ref_step(eh, h[k]);
        for (int i = 0; i < 4; i++) begin
            sp[i] = s[56*i +: 56];
            es[i] = 8'd0;
            for (int k = 0; k < 56; k++) es[i] = ref_step(es[i], sp[i][k]);
        end
        for (int c = 0; c < 32; c++) begin
            exp_stream[c][0] = (c < 24) ? h[c] : eh[c-24];
            for (int i = 0; i < 4; i++) begin
                exp_stream[c][1+i] = (c < 28) ? sp[i][2*c]   : es[i][2*(c-28)];
                exp_stream[c][5+i] = (c < 28) ? sp[i][2*c+1] : es[i][2*(c-28)+1];
            end
        end
    endfunction

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input int c, input logic [8:0] got, input logic [8:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s (idx %0d): got %h expected %h", name, c, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Called just after a rising edge; checks at the falling edge.
    task automatic step(input logic dip, input int c_exp, input logic [8:0] d_exp);
        data_island_period = dip;
        @(negedge clk_pixel);
        chk("counter", c_exp, {4'd0, counter}, c_exp[8:0]);
        chk("packet_data", c_exp, packet_data, d_exp);
        chk("packet_end", c_exp, {8'd0, packet_end}, {8'd0, (dip && c_exp == 31)});
        if (c_exp >= 24) got_hpar[c_exp-24] = packet_data[0];
        @(posedge clk_pixel);
        #1;
    endtask

    task automatic run_packet(input logic [23:0] h, input logic [223:0] s);
        header = h;
        sub    = s;
        build_stream(h, s);
        for (int c = 0; c < 32; c++) step(1'b1, c, exp_stream[c]);
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        logic [23:0]  hdr;
        logic [223:0] sb;
        logic         chk_par;
        logic [7:0]   hpar;
        logic [8:0]   first_word;
    } vec_t;

    vec_t vecs [5];

    localparam logic [223:0] SUB_A = {56'h5555555555555C, 56'hFEDCBA98765431,
                                      56'h0123456789ABC2, 56'hDEADBEEF123403};
    localparam logic [223:0] SUB_B = {56'h0F0F0F0F0F0F0F, 56'h00000000000000,
                                      56'h80000000000001, 56'hC3A50000FFFF00};

    initial begin
        vecs[0] = '{24'h000000, 224'd0,   1'b1, 8'h00, 9'h000};
        vecs[1] = '{24'h000001, 224'd0,   1'b1, 8'h4A, 9'h001};
        vecs[2] = '{24'h000000, 224'd1,   1'b0, 8'h00, 9'h002};
        vecs[3] = '{24'hA5C30F, SUB_A,    1'b0, 8'h00, 9'h06B};
        vecs[4] = '{24'hFFFFFF, '1,       1'b0, 8'h00, 9'h1FF};

        reset = 1'b1;
        data_island_period = 1'b1;
        header = 24'hA5C30F;
        sub = SUB_A;
        repeat (2) @(posedge clk_pixel);
        @(negedge clk_pixel);
        chk("reset_data", 0, packet_data, 9'h000);
        chk("reset_counter", 0, {4'd0, counter}, 9'd0);
        chk("reset_end", 0, {8'd0, packet_end}, 9'd0);
        @(posedge clk_pixel);
        #1;
        data_island_period = 1'b0;
        reset = 1'b0;

        // Table-driven packets, back to back.
        for (int v = 0; v < 5; v++) begin
            header = vecs[v].hdr;
            sub    = vecs[v].sb;
            #1;
            chk("first_word_hand", v, packet_data, vecs[v].first_word);
            run_packet(vecs[v].hdr, vecs[v].sb);
            if (vecs[v].chk_par) chk("header_parity_hand", v, {1'b0, got_hpar}, {1'b0, vecs[v].hpar});
        end

        // Island dropped for 5 clocks at counter 10, and for 1 clock at 31.
        header = 24'hA5C30F;
        sub    = SUB_A;
        build_stream(header, sub);
        for (int c = 0; c < 10; c++) step(1'b1, c, exp_stream[c]);
        repeat (5) step(1'b0, 10, exp_stream[10]);
        for (int c = 10; c < 31; c++) step(1'b1, c, exp_stream[c]);
        step(1'b0, 31, exp_stream[31]);
        step(1'b1, 31, exp_stream[31]);

        // Source changes at counter 5 must not disturb the packet in flight.
        header = 24'hA5C30F;
        sub    = SUB_A;
        build_stream(header, sub);
        for (int c = 0; c < 5; c++) step(1'b1, c, exp_stream[c]);
        header = 24'h3C5A96;
        sub    = SUB_B;
        for (int c = 5; c < 32; c++) step(1'b1, c, exp_stream[c]);
        run_packet(24'h3C5A96, SUB_B);

        // Reset pulsed at counter 17.
        header = 24'hA5C30F;
        sub    = SUB_A;
        build_stream(header, sub);
        for (int c = 0; c < 17; c++) step(1'b1, c, exp_stream[c]);
        reset = 1'b1;
        #1;
        chk("midreset_data", 17, packet_data, 9'h000);
        chk("midreset_counter", 17, {4'd0, counter}, 9'd0);
        chk("midreset_end", 17, {8'd0, packet_end}, 9'd0);
        @(posedge clk_pixel);
        #1;
        reset = 1'b0;
        run_packet(24'h3C5A96, SUB_B);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
